// File: rtl/fadd_pkg.sv
// Shared FloatAdd datapath constants: mantissa width and transfer-counter width.
package fadd_pkg;
    localparam int MANT_W = 16;
    localparam int CNT_W  = 16;
endpackage

// File: rtl/demux_slot_16.sv
// Single-entry output slot for demux1x2_16: valid flag, data register, and a
// transfer counter when DEMUX1X2_16_CNT_EN is defined.
module demux_slot_16
    import fadd_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
`ifdef DEMUX1X2_16_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic drain;

    assign drain = valid && ready;

    // A load wins over a drain in the same cycle, so the slot refills with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

`ifdef DEMUX1X2_16_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux1x2_16.sv
// Registered 1-to-2 stream demultiplexer for mantissa words; per-word select
// steers into one of two independent slots. Optional counters: DEMUX1X2_16_CNT_EN.
module demux1x2_16
    import fadd_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX1X2_16_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic accept;
    logic load0;
    logic load1;

    // Only the selected slot gates acceptance; the other slot never stalls the input.
    assign in_ready = in_sel ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
    assign accept   = in_valid && in_ready;
    assign load0    = accept && !in_sel;
    assign load1    = accept && in_sel;

    demux_slot_16 #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .load_data (in_data),
        .ready     (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data)
`ifdef DEMUX1X2_16_CNT_EN
        ,
        .cnt       (cnt0)
`endif
    );

    demux_slot_16 #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data)
`ifdef DEMUX1X2_16_CNT_EN
        ,
        .cnt       (cnt1)
`endif
    );

endmodule
